tdd_frame_sequencer: RTL



---
 rtl/tdd_frame_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tdd_frame_sequencer.sv
// TDD frame sequencer: IDLE/ARMED/WAITING/RUNNING control with startup delay,
// frame length and burst count, plus the shared frame counter for the channel comparators.
module tdd_frame_sequencer #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync_ext,
  input  logic                         tdd_sync_rst,
  input  logic                         tdd_sync,
  input  logic                         tdd_sync_soft,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic [1:0]                   tdd_cstate,
  output logic [BURST_COUNT_WIDTH-1:0] tdd_frame_index,
  output logic                         tdd_endof_frame,
  output logic                         tdd_burst_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    WAITING = 2'b10,
    RUNNING = 2'b11
  } state_t;

  state_t                       state;
  logic [REGISTER_WIDTH-1:0]    delay_q;
  logic [REGISTER_WIDTH-1:0]    flen_q;
  logic [BURST_COUNT_WIDTH-1:0] burst_q;

  logic                         sync;
  logic                         start;
  logic                         restart;
  logic [REGISTER_WIDTH-1:0]    delay_m1;
  logic [REGISTER_WIDTH-1:0]    flen_m1;
  logic [BURST_COUNT_WIDTH-1:0] index_next;
  state_t                       launch_state;

  always_comb begin
    sync         = tdd_sync | tdd_sync_soft;
    start        = !tdd_sync_ext || sync;
    restart      = tdd_sync_rst && sync && (state == WAITING || state == RUNNING);
    // Guard the decrements so a zero setting never wraps to all-ones.
    delay_m1     = (delay_q == '0) ? '0 : delay_q - REGISTER_WIDTH'(1);
    flen_m1      = (flen_q == '0) ? '0 : flen_q - REGISTER_WIDTH'(1);
    index_next   = tdd_frame_index + BURST_COUNT_WIDTH'(1);
    launch_state = (tdd_startup_delay != '0) ? WAITING : RUNNING;
    tdd_endof_frame = !rst && tdd_enable && !restart && (state == RUNNING) &&
                      (tdd_counter == flen_m1);
    tdd_burst_done  = tdd_endof_frame && (burst_q != '0) && (index_next == burst_q);
  end

  assign tdd_cstate = state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tdd_counter     <= '0;
      tdd_frame_index <= '0;
      // NOTE: shadow configuration is reset too, so a burst never starts from undefined settings.
      delay_q         <= '0;
      flen_q          <= '0;
      burst_q         <= '0;
    end else if (!tdd_enable) begin
      state           <= IDLE;
      tdd_counter     <= '0;
      tdd_frame_index <= '0;
    end else if (restart) begin
      state           <= launch_state;
      tdd_counter     <= '0;
      tdd_frame_index <= '0;
      delay_q         <= tdd_startup_delay;
      flen_q          <= tdd_frame_length;
      burst_q         <= tdd_burst_count;
    end else begin
      case (state)
        IDLE: begin
          state           <= ARMED;
          tdd_counter     <= '0;
          tdd_frame_index <= '0;
        end
        ARMED: begin
          tdd_counter <= '0;
          if (start) begin
            state   <= launch_state;
            delay_q <= tdd_startup_delay;
            flen_q  <= tdd_frame_length;
            burst_q <= tdd_burst_count;
          end
        end
        WAITING: begin
          if (tdd_counter == delay_m1) begin
            state       <= RUNNING;
            tdd_counter <= '0;
          end else begin
            tdd_counter <= tdd_counter + REGISTER_WIDTH'(1);
          end
        end
        RUNNING: begin
          if (tdd_burst_done) begin
            state           <= ARMED;
            tdd_counter     <= '0;
            tdd_frame_index <= '0;
          end else if (tdd_endof_frame) begin
            tdd_counter     <= '0;
            tdd_frame_index <= index_next;
          end else begin
            tdd_counter <= tdd_counter + REGISTER_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule
